// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the parametrised UART TX (and future RX).
//   - Parity mode encodings (2'b11 is treated as no parity).
//   - Transmit state enumeration.
//   - Minimum data width and a helper that clamps a requested width.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int unsigned NBITS_MIN = 5;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // Requested data width forced into NBITS_MIN..max_bits.
    function automatic int unsigned clamp_nbits(input logic [3:0]  nbits,
                                                input int unsigned max_bits);
        int unsigned n;
        n = 32'(nbits);
        if (n < NBITS_MIN) begin
            n = NBITS_MIN;
        end else if (n > max_bits) begin
            n = max_bits;
        end
        return n;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter shared by the UART TX and RX.
//   Clk  - system clock
//   Rst  - synchronous active-high reset, clears the counter
//   clr  - restart the bit period (takes priority over en)
//   en   - count enable
//   tick - high in the last cycle (count CLKS_PER_BIT-1) of each bit period
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned     CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    assign tick = en && !clr && (cnt_q == LAST);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with valid/ready input.
//   Clk     - system clock
//   Rst     - synchronous active-high reset (aborts any frame in flight)
//   TxData  - word to send, LSB first
//   NBits   - data bits per frame, clamped to 5..DATA_BITS_MAX
//   Parity  - 00 none, 01 even, 10 odd, 11 none
//   TwoStop - 0 one stop bit, 1 two stop bits
//   TxValid - upstream offers a word
//   TxReady - word accepted on TxValid & TxReady (idle only)
//   Tx      - serial line, idle high
//   TxBusy  - frame in progress
//   TxDone  - one-cycle pulse in the final cycle of the last stop bit
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT  = 434,
    parameter int unsigned DATA_BITS_MAX = 8
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [DATA_BITS_MAX-1:0] TxData,
    input  logic [3:0]               NBits,
    input  logic [1:0]               Parity,
    input  logic                     TwoStop,
    input  logic                     TxValid,
    output logic                     TxReady,
    output logic                     Tx,
    output logic                     TxBusy,
    output logic                     TxDone
);

    localparam int unsigned IW = (DATA_BITS_MAX > 1) ? $clog2(DATA_BITS_MAX) : 1;

    tx_state_e                state_q, state_d;
    logic                     tx_q, tx_d;
    logic                     ready_q, ready_d;
    logic                     busy_q, busy_d;
    logic [DATA_BITS_MAX-1:0] data_q, data_d;
    logic [IW-1:0]            last_idx_q, last_idx_d;
    logic [IW-1:0]            bit_idx_q, bit_idx_d;
    logic                     par_en_q, par_en_d;
    logic                     par_bit_q, par_bit_d;
    logic                     two_stop_q, two_stop_d;
    logic                     stop_idx_q, stop_idx_d;

    logic                     accept;
    logic                     tick;
    logic                     frame_end;
    int unsigned              n_acc;
    logic                     xor_acc;
    logic                     par_en_acc;
    logic                     par_odd_acc;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .Clk  (Clk),
        .Rst  (Rst),
        .clr  (accept),
        .en   (busy_q),
        .tick (tick)
    );

    assign accept = ready_q && TxValid;

    // Frame parameters evaluated from the live inputs, latched on acceptance.
    // Parity only covers the bits that will actually be sent.
    always_comb begin
        n_acc   = clamp_nbits(NBits, DATA_BITS_MAX);
        xor_acc = 1'b0;
        for (int unsigned i = 0; i < DATA_BITS_MAX; i++) begin
            if (i < n_acc) begin
                xor_acc = xor_acc ^ TxData[i];
            end
        end
        par_en_acc  = 1'b0;
        par_odd_acc = 1'b0;
        case (Parity)
            PAR_EVEN: par_en_acc = 1'b1;
            PAR_ODD: begin
                par_en_acc  = 1'b1;
                par_odd_acc = 1'b1;
            end
            PAR_NONE: par_en_acc = 1'b0;
            default:  par_en_acc = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        last_idx_d = last_idx_q;
        bit_idx_d  = bit_idx_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        two_stop_d = two_stop_q;
        stop_idx_d = stop_idx_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d     = TxData;
                    last_idx_d = IW'(n_acc - 1);
                    bit_idx_d  = '0;
                    par_en_d   = par_en_acc;
                    par_bit_d  = xor_acc ^ par_odd_acc;
                    two_stop_d = TwoStop;
                    stop_idx_d = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx_q == last_idx_q) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IW'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_idx_q == two_stop_q) begin
                        state_d = IDLE;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line and handshake outputs are decoded from the next state so the
        // registered values line up with the state they belong to.
        unique case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[bit_idx_d];
            PARITY:  tx_d = par_bit_d;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            tx_q       <= 1'b1;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            data_q     <= '0;
            last_idx_q <= '0;
            bit_idx_q  <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            stop_idx_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            data_q     <= data_d;
            last_idx_q <= last_idx_d;
            bit_idx_q  <= bit_idx_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= two_stop_d;
            stop_idx_q <= stop_idx_d;
        end
    end

    // TxDone has to coincide with the last stop-bit cycle, which is only
    // known from the baud tick in that same cycle, so it is decoded from
    // registered state rather than held in its own flop. Suppressed while
    // Rst is asserted so an aborted frame never reports completion.
    assign frame_end = (state_q == STOP) && tick && (stop_idx_q == two_stop_q);

    assign Tx      = tx_q;
    assign TxReady = ready_q;
    assign TxBusy  = busy_q;
    assign TxDone  = frame_end && !Rst;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param (CLKS_PER_BIT=4, DATA_BITS_MAX=8).
module tb_uart_tx_param;

    localparam int unsigned C = 4;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [7:0] TxData;
    logic [3:0] NBits;
    logic [1:0] Parity;
    logic       TwoStop;
    logic       TxValid;
    logic       TxReady;
    logic       Tx;
    logic       TxBusy;
    logic       TxDone;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 Clk = ~Clk;

    uart_tx_param #(
        .CLKS_PER_BIT  (C),
        .DATA_BITS_MAX (8)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .TxData  (TxData),
        .NBits   (NBits),
        .Parity  (Parity),
        .TwoStop (TwoStop),
        .TxValid (TxValid),
        .TxReady (TxReady),
        .Tx      (Tx),
        .TxBusy  (TxBusy),
        .TxDone  (TxDone)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offers one word at an idle negedge and checks the whole frame cycle by
    // cycle against a bit list built from the framing rules. Returns at the
    // idle-high negedge that follows TxDone. With hold=1 TxValid stays high
    // so the next call chains a back-to-back frame; with scramble=1 the
    // inputs are changed randomly during the frame.
    task automatic frame(input string tag, input logic [7:0] d, input logic [3:0] nb,
                         input logic [1:0] par, input logic two,
                         input bit hold, input bit scramble);
        bit          lv[$];
        int unsigned n;
        int unsigned len;
        bit          x;
        chk({tag, "_ready_pre"}, TxReady, 1);
        chk({tag, "_tx_idle"}, Tx, 1);
        TxData  = d;
        NBits   = nb;
        Parity  = par;
        TwoStop = two;
        TxValid = 1'b1;

        n = (nb < 5) ? 5 : ((nb > 8) ? 8 : 32'(nb));
        x = 1'b0;
        lv.push_back(1'b0);
        for (int unsigned i = 0; i < n; i++) begin
            lv.push_back(d[i]);
            x = x ^ d[i];
        end
        if (par == 2'b01) lv.push_back(x);
        if (par == 2'b10) lv.push_back(!x);
        lv.push_back(1'b1);
        if (two) lv.push_back(1'b1);
        len = lv.size() * C;

        @(negedge Clk);
        if (!hold) TxValid = 1'b0;
        for (int unsigned k = 0; k < len; k++) begin
            chk({tag, "_tx"}, Tx, lv[k / C]);
            chk({tag, "_busy"}, TxBusy, 1);
            chk({tag, "_ready"}, TxReady, 0);
            chk({tag, "_done"}, TxDone, (k == len - 1) ? 1 : 0);
            if (scramble) begin
                TxData  = 8'($urandom);
                NBits   = 4'($urandom);
                Parity  = 2'($urandom);
                TwoStop = 1'($urandom);
            end
            @(negedge Clk);
        end
        chk({tag, "_done_after"}, TxDone, 0);
        chk({tag, "_busy_after"}, TxBusy, 0);
    endtask

    initial begin
        Rst     = 1'b1;
        TxValid = 1'b1;
        TxData  = 8'hFF;
        NBits   = 4'd8;
        Parity  = 2'b00;
        TwoStop = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_tx", Tx, 1);
        chk("rst_ready", TxReady, 0);
        chk("rst_busy", TxBusy, 0);
        chk("rst_done", TxDone, 0);
        Rst     = 1'b0;
        TxValid = 1'b0;
        @(negedge Clk);
        chk("post_rst_ready", TxReady, 1);
        chk("post_rst_busy", TxBusy, 0);

        frame("8n1_55", 8'h55, 4'd8, 2'b00, 1'b0, 0, 0);
        frame("7e1_83", 8'h83, 4'd7, 2'b01, 1'b0, 0, 0);
        frame("5o2_1f", 8'h1F, 4'd5, 2'b10, 1'b1, 0, 0);
        frame("n2_a5", 8'hA5, 4'd2, 2'b00, 1'b0, 0, 0);
        frame("n15_a5", 8'hA5, 4'd15, 2'b01, 1'b0, 0, 0);
        frame("par11", 8'h3C, 4'd6, 2'b11, 1'b1, 0, 0);

        frame("b2b_01", 8'h01, 4'd8, 2'b00, 1'b0, 1, 1);
        frame("b2b_02", 8'h02, 4'd8, 2'b00, 1'b0, 0, 1);

        for (int r = 0; r < 12; r++) begin
            frame("rand", 8'($urandom), 4'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)), 1'($urandom), 0, 0);
        end

        // Abort during data bit 3 (cycles 17..20 after acceptance).
        chk("abort_ready_pre", TxReady, 1);
        TxData  = 8'hC6;
        NBits   = 4'd8;
        Parity  = 2'b01;
        TwoStop = 1'b0;
        TxValid = 1'b1;
        @(negedge Clk);
        TxValid = 1'b0;
        repeat (17) @(negedge Clk);
        chk("abort_bit3", Tx, 0);
        chk("abort_busy_pre", TxBusy, 1);
        Rst     = 1'b1;
        TxValid = 1'b1;
        repeat (2) begin
            @(negedge Clk);
            chk("abort_rst_tx", Tx, 1);
            chk("abort_rst_busy", TxBusy, 0);
            chk("abort_rst_ready", TxReady, 0);
            chk("abort_rst_done", TxDone, 0);
        end
        Rst     = 1'b0;
        TxValid = 1'b0;
        repeat (6) begin
            @(negedge Clk);
            chk("abort_idle_tx", Tx, 1);
            chk("abort_idle_ready", TxReady, 1);
            chk("abort_idle_busy", TxBusy, 0);
            chk("abort_idle_done", TxDone, 0);
        end
        frame("after_abort", 8'h9A, 4'd8, 2'b10, 1'b1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 TX used by the sensor-readout path.
- Adds a valid/ready handshake in place of edge-detected enable.
- Data width 5..8 bits, selectable per frame.
- Parity: none, even or odd. Stop bits: 1 or 2.
- Sits between the DHT11 frame formatter and the board RS-232 pin; feeds the PC link at the baud set by CLKS_PER_BIT.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (434 = 115200 baud at 50 MHz); legal range >= 2.
DATA_BITS_MAX, 8, width of TxData and upper clamp for NBits.

Ports:
Clk  in  1  system clock.
Rst  in  1  synchronous active-high reset.
TxData  in  DATA_BITS_MAX  word to send, LSB first.
NBits  in  4  data bits per frame; clamped to 5..DATA_BITS_MAX.
Parity  in  2  00 none, 01 even, 10 odd, 11 none.
TwoStop  in  1  0 = one stop bit, 1 = two stop bits.
TxValid  in  1  upstream has a word.
TxReady  out  1  block accepts a word this cycle.
Tx  out  1  serial line, idle high.
TxBusy  out  1  frame in progress.
TxDone  out  1  one-cycle pulse at end of frame.

Behaviour:
Reset and clocking:
- One clock; reset is synchronous and active-high on Rst.
- While Rst=1: Tx=1, TxReady=0, TxBusy=0, TxDone=0, state=IDLE, counters=0.
- Rst asserted mid-frame aborts the frame; Tx=1 on the cycle after Rst is sampled; no TxDone is issued.

State machine: IDLE, START, DATA, PARITY, STOP.
- IDLE: Tx=1, TxReady=1, TxBusy=0.
  - On TxValid&TxReady, latch TxData, clamped NBits, Parity and TwoStop into shadow registers, then go to START.
  - Inputs changing after acceptance have no effect on the current frame.
- START: Tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: Tx = shadow[bit_idx], with bit_idx running 0..N-1, each bit held CLKS_PER_BIT cycles.
  - After bit N-1: go to PARITY if parity is enabled, else STOP.
- PARITY: even mode sends the XOR of the N data bits; odd mode sends its inverse. Held CLKS_PER_BIT cycles, then go to STOP.
- STOP: Tx=1 for CLKS_PER_BIT cycles (1 stop) or 2*CLKS_PER_BIT cycles (2 stop).
  - TxDone=1 in the final cycle of the last stop bit; next cycle is IDLE.
- TxBusy=1 in every state except IDLE. TxReady=1 only in IDLE and not in reset.

Latency and timing:
- Tx falls on the first cycle after the acceptance cycle.
- Frame length = (1 + N + P + S) * CLKS_PER_BIT cycles, where P is 0 or 1 and S is 1 or 2.
- Back-to-back: with TxValid held high, the next acceptance is the IDLE cycle right after TxDone. Minimum inter-frame gap beyond the stop bits is exactly 1 clock of Tx=1.

Arithmetic and counters:
- Baud counter width is clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1, wraps, and issues a bit tick at CLKS_PER_BIT-1.
- The counter is cleared on acceptance, so every bit is exactly CLKS_PER_BIT cycles with no off-by-one.
- Clamp: NBits<5 gives N=5; NBits>DATA_BITS_MAX gives N=DATA_BITS_MAX. Data bits above N-1 are ignored for both data and parity.
- Parity=11 behaves as none.

Boundary cases:
- TxValid asserted during a frame is ignored (TxReady=0); the data is held by upstream.
- TxValid and Rst in the same cycle: reset wins, nothing is accepted.
- CLKS_PER_BIT=2 is legal and must meet the same bit timing.

Decomposition:
- Package uart_pkg:
  - parity encoding constants (PAR_NONE, PAR_EVEN, PAR_ODD);
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - NBITS_MIN=5.
- Sub-module uart_baud_gen, shared with the future parametrised RX. It is a counter with parameter CLKS_PER_BIT and ports Clk, Rst, clr, en, tick.

Test Plan:
- CLKS_PER_BIT=4, 8N1, TxData=0x55, pulse TxValid -> Tx = 0,1,0,1,0,1,0,1,0,1, each level 4 cycles; TxDone at cycle 40 after acceptance; TxReady high again on cycle 41.
- 7E1, TxData=0x83 (bits above 6 dropped, data 0x03) -> data bits 1,1,0,0,0,0,0, parity 0, stop 1; total 10 bits.
- 5O2, TxData=0x1F -> data 1,1,1,1,1, parity 0, two stop bits of 1; frame = 9 bit times = 36 cycles.
- NBits=2 and NBits=15 with 0xA5 -> frames identical to N=5 and N=8 respectively.
- TxValid held high with TxData 0x01 then 0x02 -> two frames separated by exactly 1 extra idle-high cycle; TxData changed mid-frame does not alter the frame on the wire.
- Rst pulsed during DATA bit 3 -> Tx=1, TxBusy=0, TxReady=0 during reset then 1 afterwards; no TxDone; next accepted frame is correct.
